lcd_window_timing: RTL
======================

# lcd_window_timing

Parametrised successor to the fixed-timing LCD read-window logic used with the LTM panel. Generates the pixel clock-enable, H/V counters, panel syncs and data-enable, and a prefetch read-enable that issues exactly one SDRAM FIFO read per active pixel, with a configurable lead. It also holds a frame-synchronous shadow register, so filter/mode configuration changes only at frame boundaries. It sits between the SDRAM read FIFO, the filter pipe and the panel pins.

## Interface
Parameters:
- H_TOTAL, 1056, pixel clocks per line
- H_ACT_START, 216, first active column (H_Count value)
- H_ACT, 640, active columns
- V_TOTAL, 525, lines per frame
- V_ACT_START, 35, first active line
- V_ACT, 480, active lines
- HS_W, 1, HD low width in pixel clocks
- VS_W, 1, VD low width in lines
- CLK_DIV, 2, system clocks per pixel clock (≥2)
- READ_LEAD, 2, pixel clocks Read_en leads DEN (0 ≤ READ_LEAD < H_ACT_START)
- CFG_W, 32, shadow config width

Ports:
- Clock  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  run timing; low holds the block idle
- Cfg_in  in  CFG_W  pending configuration
- Cfg_out  out  CFG_W  frame-synchronous configuration
- Clock_en  out  1  one-cycle pulse per pixel clock
- H_Count  out  11  horizontal counter
- V_Count  out  10  vertical counter
- Coord_X  out  10  active column, 0 outside the active window
- Coord_Y  out  10  active line, 0 outside the active window
- HD  out  1  horizontal sync, active low
- VD  out  1  vertical sync, active low
- DEN  out  1  data enable
- Read_en  out  1  read strobe to the SDRAM FIFO
- Frame_start  out  1  one-cycle pulse at frame origin
- Frame_count  out  32  completed frames (only with the macro)

## Operation
- Divider div_cnt counts 0..CLK_DIV-1. Clock_en=1 when div_cnt==CLK_DIV-1.
- On Clock_en, H_Count increments. At H_TOTAL-1 it wraps to 0 and V_Count increments. V_Count wraps at V_TOTAL-1 to 0.
- HD=0 iff H_Count<HS_W. VD=0 iff V_Count<VS_W.
- DEN=1 iff H_ACT_START≤H_Count<H_ACT_START+H_ACT and V_ACT_START≤V_Count<V_ACT_START+V_ACT.
- When DEN=1: Coord_X=H_Count-H_ACT_START and Coord_Y=V_Count-V_ACT_START. Otherwise both are 0.
- Read_en=1 only on cycles with div_cnt==0, H_ACT_START-READ_LEAD≤H_Count<H_ACT_START+H_ACT-READ_LEAD, and V_Count inside the active lines. This gives exactly H_ACT strobes per active line and H_ACT·V_ACT per frame.
- Frame_start=1 for the cycle where (H_Count,V_Count) becomes (0,0) by wrap. In that same cycle Cfg_out<=Cfg_in. Cfg_out never changes at any other time.
- On an Enable rise, Cfg_out<=Cfg_in and Frame_start pulses once.
- Enable=0, or Enable falling mid-frame: on the next cycle, div_cnt, H_Count and V_Count go to 0, Clock_en/DEN/Read_en/Frame_start=0, and HD=VD=1. Cfg_out is held. On re-enable the frame starts from (0,0).
- Out-of-range parameters (CLK_DIV<2, READ_LEAD≥H_ACT_START, or an active region exceeding its total) cause an elaboration error.

## Timing
- All outputs are registered. Sync, DEN, Coord and Read_en are decoded from the next-state counters, so they align with the H_Count/V_Count values in the same cycle.
- Reset values: every output is 0 except HD=1 and VD=1. Cfg_out=0 and Frame_count=0.
- Reset has priority over Enable. Reset mid-frame returns the block to its reset values on the next cycle.
- Read_en precedes the DEN of the same pixel by READ_LEAD·CLK_DIV system clocks.
- The first Clock_en after enable occurs CLK_DIV cycles after Enable is sampled high.

## Configuration
- LCD_WINDOW_FRAME_COUNT_EN defined: Frame_count increments, wrapping at 2^32-1, in each Frame_start cycle caused by a counter wrap. An Enable rise does not increment it. Enable=0 holds it; Reset clears it.
- Macro undefined: the Frame_count port is absent and no counter logic is built.

## Test plan
- Reset then Enable=1 with defaults → Clock_en every 2nd cycle; the first Frame_start is on the enable-rise cycle; the second Frame_start is 2·1056·525=1,108,800 cycles later.
- Count strobes over one frame → exactly 640 Read_en per active line and 307,200 per frame; DEN=1 for 307,200 pixel clocks; each line's first Read_en occurs 4 cycles before its first DEN.
- Change Cfg_in from 0x0 to 0x5 at V_Count=100 → Cfg_out stays 0x0 until the next Frame_start, then reads 0x5.
- Drop Enable at H_Count=300, V_Count=200 → the next cycle shows counters=0, HD=VD=1, Read_en=0. Re-enable → normal timing restarts from (0,0).
- Assert Reset for 1 cycle mid-frame → all outputs return to their reset values; Cfg_out=0.
- With LCD_WINDOW_FRAME_COUNT_EN, set CLK_DIV=4 and a small raster (H_TOTAL=20, V_TOTAL=10), then run 3 full frames → Frame_count=3 and H_Count advances every 4 cycles.

Source files
------------

// File: rtl/lcd_window_timing_if.sv
// Panel-side signal bundle for lcd_window_timing.
// Frame_count exists only when LCD_WINDOW_FRAME_COUNT_EN is defined.
interface lcd_window_timing_if #(
    parameter int CFG_W = 32
);
    logic             Enable;
    logic [CFG_W-1:0] Cfg_in;
    logic [CFG_W-1:0] Cfg_out;
    logic             Clock_en;
    logic [10:0]      H_Count;
    logic [9:0]       V_Count;
    logic [9:0]       Coord_X;
    logic [9:0]       Coord_Y;
    logic             HD;
    logic             VD;
    logic             DEN;
    logic             Read_en;
    logic             Frame_start;
`ifdef LCD_WINDOW_FRAME_COUNT_EN
    logic [31:0]      Frame_count;
`endif

    modport master (
        input  Enable, Cfg_in,
        output Cfg_out, Clock_en, H_Count, V_Count, Coord_X, Coord_Y,
               HD, VD, DEN, Read_en, Frame_start
`ifdef LCD_WINDOW_FRAME_COUNT_EN
        , output Frame_count
`endif
    );

    modport slave (
        output Enable, Cfg_in,
        input  Cfg_out, Clock_en, H_Count, V_Count, Coord_X, Coord_Y,
               HD, VD, DEN, Read_en, Frame_start
`ifdef LCD_WINDOW_FRAME_COUNT_EN
        , input Frame_count
`endif
    );
endinterface

// File: rtl/lcd_window_timing.sv
// LCD raster timing: pixel enable, H/V counters, syncs, DEN, FIFO prefetch strobe and a
// frame-synchronous config shadow. LCD_WINDOW_FRAME_COUNT_EN adds a completed-frame counter.
module lcd_window_timing #(
    parameter int H_TOTAL     = 1056,
    parameter int H_ACT_START = 216,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480,
    parameter int HS_W        = 1,
    parameter int VS_W        = 1,
    parameter int CLK_DIV     = 2,
    parameter int READ_LEAD   = 2,
    parameter int CFG_W       = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    lcd_window_timing_if.master bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_AS   = 11'(H_ACT_START);
    localparam logic [10:0] H_AE   = 11'(H_ACT_START + H_ACT);
    localparam logic [10:0] H_RS   = 11'(H_ACT_START - READ_LEAD);
    localparam logic [10:0] H_RE   = 11'(H_ACT_START + H_ACT - READ_LEAD);
    localparam logic [10:0] H_SW   = 11'(HS_W);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_AS   = 10'(V_ACT_START);
    localparam logic [9:0]  V_AE   = 10'(V_ACT_START + V_ACT);
    localparam logic [9:0]  V_SW   = 10'(VS_W);

    if (CLK_DIV < 2) begin : g_chk_div
        $error("lcd_window_timing: CLK_DIV must be at least 2");
    end
    if (READ_LEAD < 0 || READ_LEAD >= H_ACT_START) begin : g_chk_lead
        $error("lcd_window_timing: READ_LEAD must satisfy 0 <= READ_LEAD < H_ACT_START");
    end
    if (H_ACT_START + H_ACT > H_TOTAL || V_ACT_START + V_ACT > V_TOTAL) begin : g_chk_act
        $error("lcd_window_timing: active region exceeds its total");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_ACT > 1024) begin : g_chk_width
        $error("lcd_window_timing: raster does not fit the counter widths");
    end

    state_t           r_state, w_state_nx;
    logic [DW-1:0]    r_div, w_div_nx;
    logic [10:0]      r_h, w_h_nx;
    logic [9:0]       r_v, w_v_nx;
    logic             w_rise, w_wrap, w_h_act, w_v_act, w_den, w_rd;
    logic             r_ce, r_hd, r_vd, r_den, r_rd, r_fs;
    logic [9:0]       r_x, r_y;
    logic [CFG_W-1:0] r_cfg;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        w_state_nx = bus.Enable ? S_RUN : S_IDLE;
        w_rise     = bus.Enable && (r_state == S_IDLE);
        w_wrap     = 1'b0;
        w_div_nx   = r_div + DW'(1);
        w_h_nx     = r_h;
        w_v_nx     = r_v;
        if (w_rise) begin
            w_div_nx = '0;
            w_h_nx   = '0;
            w_v_nx   = '0;
        end else if (r_div == DIV_LAST) begin
            w_div_nx = '0;
            if (r_h == H_LAST) begin
                w_h_nx = '0;
                if (r_v == V_LAST) begin
                    w_v_nx = '0;
                    w_wrap = 1'b1;
                end else begin
                    w_v_nx = r_v + 10'd1;
                end
            end else begin
                w_h_nx = r_h + 11'd1;
            end
        end
    end

    // Decode from the next-state counters so registered outputs line up with H/V_Count.
    assign w_h_act = (w_h_nx >= H_AS) && (w_h_nx < H_AE);
    assign w_v_act = (w_v_nx >= V_AS) && (w_v_nx < V_AE);
    assign w_den   = w_h_act && w_v_act;
    assign w_rd    = (w_div_nx == '0) && w_v_act && (w_h_nx >= H_RS) && (w_h_nx < H_RE);

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (Reset || !bus.Enable) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_ce    <= 1'b0;
            r_hd    <= 1'b1;
            r_vd    <= 1'b1;
            r_den   <= 1'b0;
            r_rd    <= 1'b0;
            r_fs    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            if (Reset) r_cfg <= '0;
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_h     <= w_h_nx;
            r_v     <= w_v_nx;
            r_ce    <= (w_div_nx == DIV_LAST);
            r_hd    <= (w_h_nx >= H_SW);
            r_vd    <= (w_v_nx >= V_SW);
            r_den   <= w_den;
            r_rd    <= w_rd;
            r_fs    <= w_rise || w_wrap;
            r_x     <= w_den ? 10'(w_h_nx - H_AS) : '0;
            r_y     <= w_den ? 10'(w_v_nx - V_AS) : '0;
            if (w_rise || w_wrap) r_cfg <= bus.Cfg_in;
        end
    end

`ifdef LCD_WINDOW_FRAME_COUNT_EN
    logic [31:0] r_fc;

    // Only raster wraps count; an Enable rise restarts the frame without completing one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_fc <= '0;
        end else if (bus.Enable && w_wrap) begin
            r_fc <= r_fc + 32'd1;
        end
    end

    assign bus.Frame_count = r_fc;
`endif

    assign bus.Cfg_out     = r_cfg;
    assign bus.Clock_en    = r_ce;
    assign bus.H_Count     = r_h;
    assign bus.V_Count     = r_v;
    assign bus.Coord_X     = r_x;
    assign bus.Coord_Y     = r_y;
    assign bus.HD          = r_hd;
    assign bus.VD          = r_vd;
    assign bus.DEN         = r_den;
    assign bus.Read_en     = r_rd;
    assign bus.Frame_start = r_fs;
endmodule
